// File: rtl/key_op_sequencer_if.sv
// Calculator front-end bus: raw keys/switches in,
// operation select, commit state and operands out.
interface key_op_sequencer_if;
    logic [1:0] KEY;
    logic [9:0] SW;
    logic [2:0] opSel;
    logic [2:0] nextOpSel;
    logic       opCommit;
    logic       selPulse;
    logic       commitPulse;
    logic [3:0] opA;
    logic [3:0] opB;
    logic       opCin;
    logic [9:0] swSync;

    modport master (
        output KEY, SW,
        input  opSel, nextOpSel, opCommit,
        input  selPulse, commitPulse,
        input  opA, opB, opCin, swSync
    );

    modport slave (
        input  KEY, SW,
        output opSel, nextOpSel, opCommit,
        output selPulse, commitPulse,
        output opA, opB, opCin, swSync
    );
endinterface

// File: rtl/key_op_sequencer.sv
// Debounces the select/commit keys, runs the select/commit
// state machine and registers the operands for the datapath.
module key_op_sequencer #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18,
    parameter int N_OPS           = 7
) (
    input logic               MAX10_CLK1_50,
    input logic               reset_n,
    key_op_sequencer_if.slave bus
);
    typedef enum logic {
        SELECT,
        COMMITTED
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]       LAST_OP  = 3'(N_OPS - 1);

    logic [1:0]       key_meta;
    logic [1:0]       key_sync;
    logic [1:0]       stable;
    logic [1:0]       pulse;
    logic [CNT_W-1:0] cnt [2];
    logic [9:0]       sw_meta;
    logic [9:0]       sw_sync;

    state_t     state;
    state_t     state_d;
    logic [2:0] op_sel;
    logic [2:0] op_sel_d;
    logic [2:0] next_op;
    logic [2:0] next_op_d;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic       op_cin;

    always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
        if (!reset_n) begin
            key_meta <= 2'b11;
            key_sync <= 2'b11;
            sw_meta  <= '0;
            sw_sync  <= '0;
        end else begin
            key_meta <= bus.KEY;
            key_sync <= key_meta;
            sw_meta  <= bus.SW;
            sw_sync  <= sw_meta;
        end
    end

    // Press pulse fires on the same edge stable falls to 0.
    always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
        if (!reset_n) begin
            stable <= 2'b11;
            pulse  <= 2'b00;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (key_sync[i] == stable[i]) begin
                    cnt[i]   <= '0;
                    pulse[i] <= 1'b0;
                end else if (cnt[i] == CNT_LAST) begin
                    cnt[i]    <= '0;
                    stable[i] <= key_sync[i];
                    pulse[i]  <= ~key_sync[i];
                end else begin
                    cnt[i]   <= cnt[i] + 1'b1;
                    pulse[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
        if (!reset_n) begin
            state   <= SELECT;
            op_sel  <= 3'd0;
            next_op <= 3'd1;
        end else begin
            state   <= state_d;
            op_sel  <= op_sel_d;
            next_op <= next_op_d;
        end
    end

    // Commit takes priority over a coincident select.
    always_comb begin
        state_d   = state;
        op_sel_d  = op_sel;
        next_op_d = next_op;
        unique case (state)
            SELECT: begin
                if (pulse[1]) begin
                    state_d = COMMITTED;
                end else if (pulse[0]) begin
                    op_sel_d  = next_op;
                    next_op_d = (next_op == LAST_OP) ? 3'd0
                                                     : next_op + 3'd1;
                end
            end
            COMMITTED: begin
                if (pulse[1]) begin
                    state_d = SELECT;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
        if (!reset_n) begin
            op_a   <= '0;
            op_b   <= '0;
            op_cin <= 1'b0;
        end else if (state == COMMITTED) begin
            op_a   <= sw_sync[3:0];
            op_b   <= sw_sync[7:4];
            op_cin <= sw_sync[8];
        end else begin
            op_a   <= '0;
            op_b   <= '0;
            op_cin <= 1'b0;
        end
    end

    assign bus.opSel       = op_sel;
    assign bus.nextOpSel   = next_op;
    assign bus.opCommit    = (state == COMMITTED);
    assign bus.selPulse    = pulse[0];
    assign bus.commitPulse = pulse[1];
    assign bus.opA         = op_a;
    assign bus.opB         = op_b;
    assign bus.opCin       = op_cin;
    assign bus.swSync      = sw_sync;
endmodule

// File: tb/tb_key_op_sequencer.sv
// Bench for key_op_sequencer: window-based reference model
// compared every cycle, plus directed literal checks.
module tb_key_op_sequencer;
    localparam int D = 4;
    localparam int N = 7;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    key_op_sequencer_if bus();

    key_op_sequencer #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (3),
        .N_OPS          (N)
    ) dut (
        .MAX10_CLK1_50(clk),
        .reset_n      (rst_n),
        .bus          (bus.slave)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model state
    logic [2:0] m_op;
    logic [2:0] m_next;
    logic       m_commit;
    logic [1:0] m_stable;
    logic [1:0] m_pulse;
    logic [3:0] m_a;
    logic [3:0] m_b;
    logic       m_cin;
    logic [9:0] m_sw;
    logic [1:0] m_hist[$];
    logic [9:0] m_swq[$];

    // A key level is accepted once the last D synchronized samples
    // (raw samples delayed two clocks) all disagree with stable.
    task automatic model_step();
        bit settled;
        if (!rst_n) begin
            m_op = 3'd0;
            m_next = 3'd1;
            m_commit = 1'b0;
            m_stable = 2'b11;
            m_pulse = 2'b00;
            m_a = '0;
            m_b = '0;
            m_cin = 1'b0;
            m_sw = '0;
            m_hist.delete();
            for (int i = 0; i < D + 2; i++) m_hist.push_back(2'b11);
            m_swq.delete();
            m_swq.push_back(10'h0);
            m_swq.push_back(10'h0);
        end else begin
            m_a   = m_commit ? m_sw[3:0] : 4'h0;
            m_b   = m_commit ? m_sw[7:4] : 4'h0;
            m_cin = m_commit ? m_sw[8]   : 1'b0;
            if (m_pulse[1]) begin
                m_commit = ~m_commit;
            end else if (m_pulse[0] && !m_commit) begin
                m_op   = m_next;
                m_next = 3'((int'(m_next) + 1) % N);
            end
            m_swq.push_back(bus.SW);
            void'(m_swq.pop_front());
            m_sw = m_swq[0];
            m_hist.push_back(bus.KEY);
            void'(m_hist.pop_front());
            for (int k = 0; k < 2; k++) begin
                settled = 1'b1;
                for (int j = 0; j < D; j++)
                    if (m_hist[j][k] == m_stable[k]) settled = 1'b0;
                m_pulse[k] = 1'b0;
                if (settled) begin
                    m_stable[k] = ~m_stable[k];
                    m_pulse[k]  = ~m_stable[k];
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        check("m_opSel", 32'(bus.opSel), 32'(m_op));
        check("m_nextOpSel", 32'(bus.nextOpSel), 32'(m_next));
        check("m_opCommit", 32'(bus.opCommit), 32'(m_commit));
        check("m_selPulse", 32'(bus.selPulse), 32'(m_pulse[0]));
        check("m_commitPulse", 32'(bus.commitPulse), 32'(m_pulse[1]));
        check("m_opA", 32'(bus.opA), 32'(m_a));
        check("m_opB", 32'(bus.opB), 32'(m_b));
        check("m_opCin", 32'(bus.opCin), 32'(m_cin));
        check("m_swSync", 32'(bus.swSync), 32'(m_sw));
    end

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Hold key idx low for hold cycles, then release; report where the
    // press pulse first appeared and how many pulses were seen overall.
    task automatic press(input int idx, input int hold,
                         output int first, output int npulse);
        logic p;
        first  = -1;
        npulse = 0;
        @(negedge clk);
        bus.KEY[idx] = 1'b0;
        for (int i = 1; i <= hold + D + 6; i++) begin
            if (i == hold + 1) bus.KEY[idx] = 1'b1;
            @(negedge clk);
            p = (idx == 1) ? bus.commitPulse : bus.selPulse;
            if (p) begin
                npulse++;
                if (first < 0) first = i;
            end
        end
    endtask

    int first;
    int np;
    int found;

    initial begin
        bus.KEY = 2'b11;
        bus.SW  = 10'h000;

        // Reset
        repeat (3) begin
            @(negedge clk);
            check("rst_selPulse", 32'(bus.selPulse), 0);
            check("rst_commitPulse", 32'(bus.commitPulse), 0);
        end
        check("rst_opSel", 32'(bus.opSel), 0);
        check("rst_nextOpSel", 32'(bus.nextOpSel), 1);
        check("rst_opCommit", 32'(bus.opCommit), 0);
        check("rst_opA", 32'(bus.opA), 0);
        check("rst_opB", 32'(bus.opB), 0);
        check("rst_opCin", 32'(bus.opCin), 0);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_opSel", 32'(bus.opSel), 0);

        // Single press
        press(0, 20, first, np);
        check("single_latency", 32'(first), 6);
        check("single_count", 32'(np), 1);
        check("single_opSel", 32'(bus.opSel), 1);
        check("single_nextOpSel", 32'(bus.nextOpSel), 2);

        // Bounce
        np = 0;
        repeat (5) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                bus.KEY[0] = (i < 2) ? 1'b0 : 1'b1;
                if (bus.selPulse) np++;
            end
        end
        repeat (10) begin
            @(negedge clk);
            if (bus.selPulse) np++;
        end
        check("bounce_count", 32'(np), 0);
        check("bounce_opSel", 32'(bus.opSel), 1);

        // Wrap
        do_reset();
        for (int i = 1; i <= 7; i++) begin
            press(0, 8, first, np);
            check("wrap_opSel", 32'(bus.opSel), 32'(i % 7));
        end
        check("wrap_nextOpSel", 32'(bus.nextOpSel), 1);

        // Commit and operands
        press(0, 8, first, np);
        press(0, 8, first, np);
        check("pre_commit_opSel", 32'(bus.opSel), 2);
        bus.SW = 10'h1A5;
        @(negedge clk);
        bus.KEY[1] = 1'b0;
        found = 0;
        for (int i = 0; i < 12 && found == 0; i++) begin
            @(negedge clk);
            if (bus.commitPulse) found = 1;
        end
        check("commit_pulse_seen", 32'(found), 1);
        @(negedge clk);
        check("commit_opCommit", 32'(bus.opCommit), 1);
        check("commit_opA_lag", 32'(bus.opA), 0);
        @(negedge clk);
        check("commit_opA", 32'(bus.opA), 5);
        check("commit_opB", 32'(bus.opB), 4'hA);
        check("commit_opCin", 32'(bus.opCin), 1);
        bus.KEY[1] = 1'b1;
        repeat (D + 6) @(negedge clk);
        press(0, 8, first, np);
        check("committed_sel_pulse", 32'(np), 1);
        check("committed_opSel", 32'(bus.opSel), 2);
        @(negedge clk);
        bus.KEY[1] = 1'b0;
        found = 0;
        for (int i = 0; i < 12 && found == 0; i++) begin
            @(negedge clk);
            if (bus.commitPulse) found = 1;
        end
        check("uncommit_pulse_seen", 32'(found), 1);
        @(negedge clk);
        check("uncommit_opCommit", 32'(bus.opCommit), 0);
        check("uncommit_opA_lag", 32'(bus.opA), 5);
        @(negedge clk);
        check("uncommit_opA", 32'(bus.opA), 0);
        bus.KEY[1] = 1'b1;
        repeat (D + 6) @(negedge clk);

        // Simultaneous presses, from SELECT then from COMMITTED
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            bus.KEY = 2'b00;
            repeat (10) @(negedge clk);
            bus.KEY = 2'b11;
            repeat (D + 6) @(negedge clk);
            check("simul_opCommit", 32'(bus.opCommit), 32'(r == 0));
            check("simul_opSel", 32'(bus.opSel), 2);
            check("simul_nextOpSel", 32'(bus.nextOpSel), 3);
        end

        // Reset while the select key is held
        @(negedge clk);
        bus.KEY[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst_no_pulse", 32'(bus.selPulse), 0);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        first = -1;
        np = 0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (bus.selPulse) begin
                np++;
                if (first < 0) first = i;
            end
        end
        check("midrst_latency", 32'(first), 6);
        check("midrst_count", 32'(np), 1);
        check("midrst_opSel", 32'(bus.opSel), 1);
        bus.KEY[0] = 1'b1;
        repeat (D + 6) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/key_op_sequencer.md
Name: key_op_sequencer

Overview:
Synchronous input front-end for the calculator. It conditions the raw push-buttons and switches, then drives the operation-select and commit state that the display and arithmetic datapath consume. The block debounces KEY[1:0] and produces one-cycle press pulses. It runs the select/commit state machine on clean clock-domain logic and presents registered operands to the arithmetic modules. It is the input end of the path whose output end is the seven-segment display chain.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive clocks a synchronized key must differ from its stable state before the change is accepted (5 ms at 50 MHz).
CNT_W, 18, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
N_OPS, 7, number of selectable operations. Codes 0..N_OPS-1 are add, sub, mult, div, fac, exp, cos.

Ports:
MAX10_CLK1_50  input  1  system clock, 50 MHz
reset_n  input  1  asynchronous active-low reset
KEY  input  2  raw push-buttons, active-low (pressed = 0). KEY[0] = select, KEY[1] = commit.
SW  input  10  raw slide switches
opSel  output  3  current operation code
nextOpSel  output  3  code that the next select press will load
opCommit  output  1  1 = operation committed (datapath live)
selPulse  output  1  one-cycle debounced KEY[0] press
commitPulse  output  1  one-cycle debounced KEY[1] press
opA  output  4  operand A
opB  output  4  operand B
opCin  output  1  carry-in / flag bit
swSync  output  10  synchronized switch value

Behaviour:
- Clock and reset: one clock, MAX10_CLK1_50. Reset is asynchronous and active-low on reset_n. All state resets asynchronously.
- Reset values:
  - opSel=0, nextOpSel=1, opCommit=0.
  - selPulse=0, commitPulse=0.
  - opA=0, opB=0, opCin=0.
  - swSync=0.
  - Internal: key synchronizers=2'b11, stable key state=2'b11 (released), debounce counters=0.
- Synchronizers:
  - KEY and SW each pass through a 2-flop synchronizer.
  - swSync is the second flop stage.
- Debounce (one independent instance per key):
  - When the synchronized key differs from the stable state, the counter increments each clock.
  - If the synchronized key returns to the stable value, the counter clears to 0.
  - On the clock where the counter equals DEBOUNCE_CYCLES-1 and the key still differs: stable <= synchronized value and counter <= 0.
- Press pulse:
  - The pulse is asserted for exactly one cycle, registered on the same edge that stable goes 1->0.
  - A release (0->1) produces no pulse.
  - Latency from the first edge that samples KEY low to pulse high is DEBOUNCE_CYCLES+2 clocks.
  - Glitches shorter than DEBOUNCE_CYCLES clocks produce no pulse.
- FSM states are SELECT (opCommit=0) and COMMITTED (opCommit=1).
  - SELECT + selPulse: opSel <= nextOpSel; nextOpSel <= nextOpSel+1, wrapping N_OPS-1 -> 0.
  - With the defaults the sequence is 0->1->...->6->0. opSel therefore wraps to 0 after 6, and no press is ever swallowed at the wrap.
  - SELECT + commitPulse -> COMMITTED. opSel and nextOpSel are held.
  - COMMITTED + commitPulse -> SELECT.
  - COMMITTED + selPulse: ignored.
  - selPulse and commitPulse in the same cycle: commit wins and the select is discarded, in either state.
- Operands (registered, 1-cycle delay from swSync):
  - In COMMITTED: opA <= swSync[3:0], opB <= swSync[7:4], opCin <= swSync[8].
  - In SELECT: opA, opB and opCin are forced to 0.
  - The first cycle after entering COMMITTED already loads from swSync.
  - swSync[9] is passed through only; it does not feed the operands.
- No arithmetic is performed here; opSel and opCommit drive the downstream selection decode directly. The downstream case code is {opCommit, opSel}.
- Reset mid-press:
  - Debounce counters clear and stable returns to released.
  - A key still held after reset deasserts is seen as a new press after DEBOUNCE_CYCLES+2 clocks.
  - A key still held after reset deasserts generates exactly one pulse.
- Held key: a held key produces a single pulse; there is no auto-repeat.

Test Plan:
- DEBOUNCE_CYCLES=4, reset: drive reset_n low for 3 cycles with KEY=2'b11, then release. Check opSel=0, nextOpSel=1, opCommit=0, opA/opB/opCin=0, and both pulses 0 throughout.
- Single press: KEY[0] low for 20 cycles. selPulse is high for exactly 1 cycle, 6 clocks after the first low sample. opSel=1, nextOpSel=2.
- Bounce: KEY[0] toggles low for 2 cycles then high, repeated 5 times. No selPulse occurs and opSel is unchanged.
- Wrap: 7 clean KEY[0] presses from reset. opSel goes 1,2,3,4,5,6,0 and nextOpSel ends at 1.
- Commit and operands:
  - opSel=2, SW=10'h1A5, press KEY[1]. opCommit=1 and the next cycle shows opA=5, opB=A, opCin=1.
  - A further KEY[0] press leaves opSel=2.
  - A second KEY[1] press returns opCommit=0, with opA=0 one cycle later.
- Simultaneous and reset-mid-press:
  - Both keys pressed in the same cycle: only commitPulse is acted on and opSel is unchanged.
  - Assert reset_n during a KEY[0] hold at count 2, then release with the key still held. Exactly one selPulse occurs, 6 clocks after reset deassertion.
